// File: rtl/lr2_pkg.sv
// Shared types and constants for the lr2 sweep sequencer.
package lr2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN_UP = 3'd2,
    RUN_DN = 3'd3,
    DONE   = 3'd4
  } lr2_sweep_state_t;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_RST_VAL = '0;

  function automatic logic lr2_is_run(input lr2_sweep_state_t s);
    return (s == RUN_UP) || (s == RUN_DN);
  endfunction

endpackage

// File: rtl/lr2_prescaler.sv
// Step-rate prescaler: counts 0..DIV while enabled and ticks on the terminal count.
module lr2_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_count;
  logic             w_term;

  assign w_term = (r_count == i_div);
  assign o_tick = w_term && i_en;

  // Holding (rather than clearing) when disabled lets a pause resume mid-period.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_term ? '0 : r_count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/lr2_sweep_ctrl.sv
// Sweep sequencer for the 4-bit loadable up/down counter, with a shadow count.
// Optional PAUSE input is enabled by defining LR2_SWEEP_PAUSE_EN.
module lr2_sweep_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
`ifdef LR2_SWEEP_PAUSE_EN
  input  logic             i_pause,
`endif
  input  logic [CNT_W-1:0] i_lo,
  input  logic [CNT_W-1:0] i_hi,
  input  logic             i_mode,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_cnt_ce,
  output logic             o_cnt_load,
  output logic [CNT_W-1:0] o_cnt_dat,
  output logic             o_cnt_up,
  output logic [CNT_W-1:0] o_pos,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  import lr2_pkg::*;

  lr2_sweep_state_t r_state;
  logic [CNT_W-1:0] r_pos;
  logic [CNT_W-1:0] r_lo;
  logic [CNT_W-1:0] r_hi;
  logic             r_mode;
  logic [DIV_W-1:0] r_div;
  logic             r_err;

  logic w_pause;
  logic w_run;
  logic w_atBound;
  logic w_reverse;
  logic w_preClr;
  logic w_preEn;
  logic w_tick;

`ifdef LR2_SWEEP_PAUSE_EN
  assign w_pause = i_pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_run     = lr2_is_run(r_state);
  assign w_atBound = (r_state == RUN_UP) ? (r_pos == r_hi) : (r_pos == r_lo);
  assign w_reverse = w_run && w_atBound && r_mode && (r_lo != r_hi) && !w_pause && !i_stop;
  assign w_preClr  = (r_state == LOAD) || w_reverse;
  assign w_preEn   = w_run && !w_atBound && !w_pause && !i_stop;

  lr2_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_preClr),
    .i_en   (w_preEn),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  // Counter controls are pure decodes so the counter moves on the same edge as POS.
  assign o_cnt_ce   = w_tick;
  assign o_cnt_load = (r_state == LOAD);
  assign o_cnt_dat  = (r_state == LOAD) ? r_lo : '0;
  assign o_cnt_up   = (r_state == RUN_UP);
  assign o_pos      = r_pos;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = (r_state == DONE);
  assign o_err      = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_pos   <= CNT_RST_VAL;
      r_lo    <= '0;
      r_hi    <= '0;
      r_mode  <= 1'b0;
      r_div   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_lo <= i_hi) begin
              r_lo    <= i_lo;
              r_hi    <= i_hi;
              r_mode  <= i_mode;
              r_div   <= i_div;
              r_state <= LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (i_stop) begin
            r_state <= IDLE;
          end else begin
            r_pos   <= r_lo;
            r_state <= RUN_UP;
          end
        end
        // A degenerate ping-pong (LO==HI) parks here until STOP.
        RUN_UP: begin
          if (i_stop) begin
            r_state <= IDLE;
          end else if (!w_pause) begin
            if (w_atBound) begin
              if (!r_mode) begin
                r_state <= DONE;
              end else if (r_lo != r_hi) begin
                r_state <= RUN_DN;
              end
            end else if (w_tick) begin
              r_pos <= r_pos + CNT_W'(1);
            end
          end
        end
        RUN_DN: begin
          if (i_stop) begin
            r_state <= IDLE;
          end else if (!w_pause) begin
            if (w_atBound) begin
              r_state <= RUN_UP;
            end else if (w_tick) begin
              r_pos <= r_pos - CNT_W'(1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
